// File: rtl/byte_store_pkg.sv
// Shared types and the byte-lane merge helper for the byte_store_bank scratch storage.
// The merge works on a maximum-width word; callers widen their operands and truncate the result.
package byte_store_pkg;

    localparam int MAX_BYTES = 16;

    typedef logic [8*MAX_BYTES-1:0] word_t;
    typedef logic [MAX_BYTES-1:0]   be_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // Lanes with be[i]=1 take new_word, all other lanes keep old_word.
    function automatic word_t byte_merge(input word_t old_word, input word_t new_word, input be_t be);
        word_t result;
        result = old_word;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/byte_store_bank.sv
// DEPTH x BYTES-byte scratch bank: per-byte writes, one-cycle registered reads with a valid
// strobe, selectable read-during-write behaviour and a one-word-per-cycle bulk clear sweep.
module byte_store_bank
    import byte_store_pkg::*;
#(
    parameter int BYTES = 4,
    parameter int DEPTH = 16,
    parameter int FWD   = 1,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [BYTES-1:0]   wr_be,
    input  logic [8*BYTES-1:0] wr_data,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic [8*BYTES-1:0] rd_data,
    output logic               rd_valid,
    input  logic               clr_start,
    output logic               busy
);

    localparam int              W         = 8 * BYTES;
    localparam logic [AW:0]     DEPTH_EXT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

    logic [W-1:0] mem [DEPTH];
    state_e       state;
    logic [AW-1:0] ptr;

    logic         wr_hit;
    logic         rd_hit;
    logic [W-1:0] wr_merged;
    logic [W-1:0] rd_word;
    logic [W-1:0] rd_next;

    // Addresses at or beyond DEPTH fall outside the array when DEPTH is not a power of two.
    assign wr_hit = wr_en && ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_hit = rd_en && ({1'b0, rd_addr} < DEPTH_EXT);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_word   = '0;
        wr_merged = '0;
        if (rd_hit) begin
            rd_word = mem[rd_addr];
        end
        if (wr_hit) begin
            wr_merged = W'(byte_merge(word_t'(mem[wr_addr]), word_t'(wr_data), be_t'(wr_be)));
        end
        rd_next = rd_word;
        if (FWD != 0 && wr_hit && rd_hit && (wr_addr == rd_addr)) begin
            rd_next = wr_merged;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the array is cleared on reset because readers rely on all words reading zero afterwards.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data  <= '0;
            rd_valid <= 1'b0;
            state    <= IDLE;
            ptr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_hit) begin
                        mem[wr_addr] <= wr_merged;
                    end
                    rd_valid <= rd_en;
                    if (rd_en) begin
                        rd_data <= rd_next;
                    end
                    // Same-cycle write/read complete before the sweep starts.
                    if (clr_start) begin
                        state <= CLEAR;
                        ptr   <= '0;
                    end
                end
                CLEAR: begin
                    rd_valid <= 1'b0;
                    mem[ptr] <= '0;
                    if (ptr == LAST_ADDR) begin
                        state <= IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == CLEAR);

endmodule
